ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_seq_pkg.sv | 53 +++++
 rtl/ctrl_seq_wait_cnt.sv | 23 ++
 rtl/ctrl_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared constants, state encoding and control-word layout for ctrl_sequencer.
// CTRL_SEQ_BRANCH_EN enables the br execute sequence.
package ctrl_seq_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] SEL_R0   = 5'b00000;
  localparam logic [4:0] SEL_ROUT = 5'b00001;
  localparam logic [4:0] SEL_ZLO  = 5'b10011;
  localparam logic [4:0] SEL_PC   = 5'b10100;
  localparam logic [4:0] SEL_MDR  = 5'b10101;
  localparam logic [4:0] SEL_C    = 5'b11000;

  localparam logic [3:0] ALU_ADD = 4'b0011;

`ifdef CTRL_SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1M, S_T2, S_DEC, S_EX, S_DONE, S_HALT, S_ERR
  } state_t;

  typedef struct packed {
    logic inc_pc, e_pc, e_ir, e_y, e_z, e_mdr, e_mar, e_rin, e_rout, e_con_ff;
    logic gra, grb, ba_out, imm_sel, ram_read, ram_write, mdr_read;
    logic busy, done, halted, illegal;
    logic [4:0] sel;
    logic [3:0] alu;
  } ctl_t;

  // Final execute step for each opcode that reaches S_EX.
  function automatic logic [3:0] last_step(input logic [4:0] op);
    case (op)
      OP_LD:   return 4'd8;
      OP_ST:   return 4'd7;
      OP_BR:   return 4'd6;
      default: return 4'd5;
    endcase
  endfunction

  function automatic logic ex_legal(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST) || (BR_EN && op == OP_BR);
  endfunction

endpackage

// File: rtl/ctrl_seq_wait_cnt.sv
// Memory wait down-counter: load with MEM_WAIT, count while waiting, expire at zero.
module ctrl_seq_wait_cnt #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] init,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (clear)                    cnt <= '0;
    else if (load)                cnt <= init;
    else if (count && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore control sequencer: fetch, decode, execute ld/ldi/st/br/nop/halt.
// The br sequence is present only when CTRL_SEQ_BRANCH_EN is defined.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int OPC_W    = 5,
  parameter int SEL_W    = 5,
  parameter int ALU_W    = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             con_ff,
  output logic             incPC,
  output logic             e_PC,
  output logic             e_IR,
  output logic             e_Y,
  output logic             e_Z,
  output logic             e_MDR,
  output logic             e_MAR,
  output logic             e_Rin,
  output logic             e_Rout,
  output logic             e_CON_FF,
  output logic             Gra,
  output logic             Grb,
  output logic             BAout,
  output logic             imm_sel,
  output logic             ram_read,
  output logic             ram_write,
  output logic             MDR_read,
  output logic [SEL_W-1:0] BusDataSelect,
  output logic [ALU_W-1:0] ALU_op,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             illegal
);

  state_t           state, nxt;
  logic [3:0]       step, step_nxt;
  logic [OPC_W-1:0] op, op_nxt;
  logic [4:0]       o5;
  logic             is_ld, expire, wait_load, wait_count;
  ctl_t             ctl, ctl_nxt;

  assign op_nxt     = (state == S_DEC) ? ir_opcode : op;
  assign o5         = 5'(op_nxt);
  assign is_ld      = (op == OPC_W'(OP_LD));
  assign wait_load  = (state == S_T0) || (state == S_EX && is_ld && step == 4'd5);
  assign wait_count = (state == S_T1) || (state == S_EX && is_ld && step == 4'd6);

  ctrl_seq_wait_cnt #(.W(3)) u_wait (
    .clock  (clock),
    .clear  (clear),
    .load   (wait_load),
    .count  (wait_count),
    .init   (3'(MEM_WAIT)),
    .expire (expire)
  );

  always_comb begin
    nxt      = state;
    step_nxt = step;
    case (state)
      S_IDLE: if (run) nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   if (expire) nxt = S_T1M;
      S_T1M:  nxt = S_T2;
      S_T2:   nxt = S_DEC;
      S_DEC: begin
        step_nxt = 4'd3;
        if (5'(ir_opcode) == OP_NOP)        nxt = S_DONE;
        else if (5'(ir_opcode) == OP_HALT)  nxt = S_HALT;
        else if (ex_legal(5'(ir_opcode)))   nxt = S_EX;
        else                                nxt = S_ERR;
      end
      S_EX: begin
        // ld T6 holds until the memory wait expires
        if (!(is_ld && step == 4'd6 && !expire)) begin
          if (step == last_step(5'(op))) begin
            nxt      = S_DONE;
            step_nxt = '0;
          end else begin
            step_nxt = step + 4'd1;
          end
        end
      end
      S_DONE:  nxt = run ? S_T0 : S_IDLE;
      default: nxt = state;
    endcase
  end

  // Outputs are decoded from the next state and registered with it.
  always_comb begin
    ctl_nxt      = '0;
    ctl_nxt.busy = !(nxt inside {S_IDLE, S_HALT, S_ERR});
    case (nxt)
      S_T0:   begin ctl_nxt.sel = SEL_PC; ctl_nxt.e_mar = 1'b1; ctl_nxt.inc_pc = 1'b1; end
      S_T1:   ctl_nxt.ram_read = 1'b1;
      S_T1M:  begin ctl_nxt.mdr_read = 1'b1; ctl_nxt.e_mdr = 1'b1; end
      S_T2:   begin ctl_nxt.sel = SEL_MDR; ctl_nxt.e_ir = 1'b1; end
      S_DONE: ctl_nxt.done    = 1'b1;
      S_HALT: ctl_nxt.halted  = 1'b1;
      S_ERR:  ctl_nxt.illegal = 1'b1;
      S_EX: begin
        if (BR_EN && o5 == OP_BR) begin
          case (step_nxt)
            4'd3: begin ctl_nxt.gra = 1'b1; ctl_nxt.e_rout = 1'b1; ctl_nxt.sel = SEL_ROUT; ctl_nxt.e_con_ff = 1'b1; end
            4'd4: begin ctl_nxt.sel = SEL_PC; ctl_nxt.e_y = 1'b1; end
            4'd5: begin ctl_nxt.imm_sel = 1'b1; ctl_nxt.alu = ALU_ADD; ctl_nxt.e_z = 1'b1; ctl_nxt.sel = SEL_C; end
            4'd6: begin ctl_nxt.sel = SEL_ZLO; ctl_nxt.e_pc = 1'b1; end
            default: ;
          endcase
        end else begin
          case (step_nxt)
            4'd3: begin ctl_nxt.grb = 1'b1; ctl_nxt.ba_out = 1'b1; ctl_nxt.e_y = 1'b1; end
            4'd4: begin ctl_nxt.imm_sel = 1'b1; ctl_nxt.alu = ALU_ADD; ctl_nxt.e_z = 1'b1; end
            4'd5: begin
              ctl_nxt.sel = SEL_ZLO;
              if (o5 == OP_LDI) begin ctl_nxt.gra = 1'b1; ctl_nxt.e_rin = 1'b1; end
              else ctl_nxt.e_mar = 1'b1;
            end
            4'd6: begin
              if (o5 == OP_LD) ctl_nxt.ram_read = 1'b1;
              else begin ctl_nxt.gra = 1'b1; ctl_nxt.e_rout = 1'b1; ctl_nxt.sel = SEL_ROUT; ctl_nxt.e_mdr = 1'b1; end
            end
            4'd7: begin
              if (o5 == OP_LD) begin ctl_nxt.mdr_read = 1'b1; ctl_nxt.e_mdr = 1'b1; end
              else ctl_nxt.ram_write = 1'b1;
            end
            4'd8: begin ctl_nxt.sel = SEL_MDR; ctl_nxt.gra = 1'b1; ctl_nxt.e_rin = 1'b1; end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_IDLE;
      step  <= '0;
      op    <= '0;
      ctl   <= '0;
    end else begin
      state <= nxt;
      step  <= step_nxt;
      op    <= op_nxt;
      ctl   <= ctl_nxt;
    end
  end

  // Branch target load qualified by the live condition flop during T6.
  assign e_PC          = ctl.e_pc & con_ff;
  assign incPC         = ctl.inc_pc;
  assign e_IR          = ctl.e_ir;
  assign e_Y           = ctl.e_y;
  assign e_Z           = ctl.e_z;
  assign e_MDR         = ctl.e_mdr;
  assign e_MAR         = ctl.e_mar;
  assign e_Rin         = ctl.e_rin;
  assign e_Rout        = ctl.e_rout;
  assign e_CON_FF      = ctl.e_con_ff;
  assign Gra           = ctl.gra;
  assign Grb           = ctl.grb;
  assign BAout         = ctl.ba_out;
  assign imm_sel       = ctl.imm_sel;
  assign ram_read      = ctl.ram_read;
  assign ram_write     = ctl.ram_write;
  assign MDR_read      = ctl.mdr_read;
  assign BusDataSelect = SEL_W'(ctl.sel);
  assign ALU_op        = ALU_W'(ctl.alu);
  assign busy          = ctl.busy;
  assign done          = ctl.done;
  assign halted        = ctl.halted;
  assign illegal       = ctl.illegal;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench: per-instruction expected output traces built from the step tables.
module tb_ctrl_sequencer;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010;
  localparam logic [4:0] BR = 5'b10010, NOP = 5'b11010, HLT = 5'b11011;
  localparam logic [4:0] ROUT = 5'b00001, ZLO = 5'b10011, PCO = 5'b10100, MDRO = 5'b10101, COUT = 5'b11000;
  localparam logic [3:0] ADD = 4'b0011;
`ifdef CTRL_SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  // Expected-vector bit layout; bit 30 marks "e_PC follows con_ff".
  localparam logic [30:0] PCF  = 31'h1 << 30, INC  = 31'h1 << 29, EIR  = 31'h1 << 27;
  localparam logic [30:0] EY   = 31'h1 << 26, EZ   = 31'h1 << 25, EMDR = 31'h1 << 24;
  localparam logic [30:0] EMAR = 31'h1 << 23, ERIN = 31'h1 << 22, EROUT = 31'h1 << 21;
  localparam logic [30:0] ECON = 31'h1 << 20, GRA  = 31'h1 << 19, GRB  = 31'h1 << 18;
  localparam logic [30:0] BA   = 31'h1 << 17, IMM  = 31'h1 << 16, RR   = 31'h1 << 15;
  localparam logic [30:0] RW   = 31'h1 << 14, MDRR = 31'h1 << 13, BUSY = 31'h1 << 3;
  localparam logic [30:0] DN   = 31'h1 << 2,  HALTED = 31'h1 << 1, ILL = 31'h1;

  logic       clk = 1'b0;
  logic       clear, run, con_ff, sel;
  logic [4:0] ir_opcode;
  wire        clr_a = clear | sel;
  wire        clr_b = clear | ~sel;
  wire [29:0] va, vb;
  wire [29:0] obs = sel ? vb : va;

  int checks = 0;
  int errors = 0;
  int mw;
  logic [30:0] sq[$];

  always #5 clk = ~clk;

  ctrl_sequencer #(.MEM_WAIT(1)) dut_a (
    .clock(clk), .clear(clr_a), .run(run), .ir_opcode(ir_opcode), .con_ff(con_ff),
    .incPC(va[29]), .e_PC(va[28]), .e_IR(va[27]), .e_Y(va[26]), .e_Z(va[25]),
    .e_MDR(va[24]), .e_MAR(va[23]), .e_Rin(va[22]), .e_Rout(va[21]), .e_CON_FF(va[20]),
    .Gra(va[19]), .Grb(va[18]), .BAout(va[17]), .imm_sel(va[16]), .ram_read(va[15]),
    .ram_write(va[14]), .MDR_read(va[13]), .BusDataSelect(va[12:8]), .ALU_op(va[7:4]),
    .busy(va[3]), .done(va[2]), .halted(va[1]), .illegal(va[0])
  );

  ctrl_sequencer #(.MEM_WAIT(3)) dut_b (
    .clock(clk), .clear(clr_b), .run(run), .ir_opcode(ir_opcode), .con_ff(con_ff),
    .incPC(vb[29]), .e_PC(vb[28]), .e_IR(vb[27]), .e_Y(vb[26]), .e_Z(vb[25]),
    .e_MDR(vb[24]), .e_MAR(vb[23]), .e_Rin(vb[22]), .e_Rout(vb[21]), .e_CON_FF(vb[20]),
    .Gra(vb[19]), .Grb(vb[18]), .BAout(vb[17]), .imm_sel(vb[16]), .ram_read(vb[15]),
    .ram_write(vb[14]), .MDR_read(vb[13]), .BusDataSelect(vb[12:8]), .ALU_op(vb[7:4]),
    .busy(vb[3]), .done(vb[2]), .halted(vb[1]), .illegal(vb[0])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] S(input logic [4:0] s);
    return 31'(s) << 8;
  endfunction

  function automatic logic [30:0] A(input logic [3:0] a);
    return 31'(a) << 4;
  endfunction

  task automatic tick(input logic c, input logic r, input logic [4:0] o, input logic cf);
    @(negedge clk);
    clear = c; run = r; ir_opcode = o; con_ff = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic pb(input logic [30:0] v);
    sq.push_back(v | BUSY);
  endtask

  // Expected trace from T0 entry through DONE (or the sticky HALT/ERR window).
  task automatic build(input logic [4:0] op, output bit sticky);
    sq.delete();
    sticky = 1'b0;
    pb(INC | EMAR | S(PCO));
    for (int i = 0; i <= mw; i++) pb(RR);
    pb(MDRR | EMDR);
    pb(EIR | S(MDRO));
    pb('0);
    if (op == LDI || op == LD || op == ST) begin
      pb(GRB | BA | EY);
      pb(IMM | A(ADD) | EZ);
    end
    if (op == LDI) pb(GRA | ERIN | S(ZLO));
    else if (op == LD) begin
      pb(S(ZLO) | EMAR);
      for (int i = 0; i <= mw; i++) pb(RR);
      pb(MDRR | EMDR);
      pb(S(MDRO) | GRA | ERIN);
    end else if (op == ST) begin
      pb(S(ZLO) | EMAR);
      pb(GRA | EROUT | S(ROUT) | EMDR);
      pb(RW);
    end else if (op == BR && BR_EN) begin
      pb(GRA | EROUT | S(ROUT) | ECON);
      pb(S(PCO) | EY);
      pb(IMM | A(ADD) | EZ | S(COUT));
      pb(S(ZLO) | PCF);
    end else if (op != NOP) begin
      sticky = 1'b1;
      repeat (op == HLT ? 50 : 20) sq.push_back(op == HLT ? HALTED : ILL);
    end
    if (!sticky) pb(DN);
  endtask

  task automatic do_clear();
    tick(1'b1, 1'($urandom), 5'($urandom), 1'($urandom));
    chk("clear", 32'(obs), 32'h0);
  endtask

  // Run one instruction; opcode is only valid on the edge leaving DEC, run only matters at DONE.
  task automatic do_instr(input logic [4:0] op, input bit keep, input int abort_k);
    bit          sticky;
    logic        cf, r;
    logic [30:0] e;
    logic [29:0] ev;
    build(op, sticky);
    for (int k = 0; k < sq.size(); k++) begin
      cf = 1'($urandom);
      r  = (k == 0 || sticky) ? 1'b1 : 1'($urandom);
      tick(k == abort_k, r, (k == mw + 5) ? op : 5'($urandom), cf);
      e  = (k == abort_k) ? '0 : sq[k];
      ev = e[29:0];
      ev[28] = e[30] & cf;
      chk($sformatf("mw%0d_op%b_k%0d", mw, op, k), 32'(obs), 32'(ev));
      if (k == abort_k) return;
    end
    if (sticky) do_clear();
    else if (!keep) begin
      int n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        tick(1'b0, 1'b0, 5'($urandom), 1'($urandom));
        chk("idle", 32'(obs), 32'h0);
      end
    end
  endtask

  function automatic logic [4:0] pick();
    int unsigned r = $urandom_range(0, 19);
    logic [4:0]  o;
    if (r < 4)        o = LD;
    else if (r < 8)   o = LDI;
    else if (r < 12)  o = ST;
    else if (r < 16)  o = BR;
    else if (r < 18)  o = NOP;
    else if (r == 18) o = HLT;
    else begin
      o = 5'($urandom);
      while (o inside {LD, LDI, ST, BR, NOP, HLT}) o = 5'($urandom);
    end
    return o;
  endfunction

  task automatic rand_run(input int cnt);
    for (int i = 0; i < cnt; i++)
      do_instr(pick(), 1'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : -1);
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; ir_opcode = '0; con_ff = 1'b0; sel = 1'b0; mw = 1;
    do_clear();
    do_instr(LDI, 1'b1, -1);
    do_instr(BR, 1'b1, -1);
    do_instr(BR, 1'b0, -1);
    do_instr(ST, 1'b0, -1);
    do_instr(LD, 1'b1, -1);
    do_instr(NOP, 1'b0, -1);
    do_instr(5'b01111, 1'b0, -1);
    do_instr(HLT, 1'b0, -1);
    rand_run(40);

    sel = 1'b1; mw = 3;
    do_clear();
    do_instr(LD, 1'b0, mw + 10);
    do_instr(LD, 1'b1, -1);
    do_instr(BR, 1'b0, -1);
    rand_run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
